logic_unit_pipe: RTL and testbench
==================================

// Module: logic_unit_pipe
// PURPOSE
//  Parametrised, pipelined bitwise logic unit; successor to the fixed 32-bit per-bit XOR array.
//  Selects one of six bitwise ops or two XOR-accumulate ops per transaction.
//  Registered valid/ready stream in and out, with zero and parity flags.
//  Sits beside the adder/shifter in the ALU datapath; also serves as a running XOR checksum engine.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (>=2)
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  in_valid    in   1      input transaction valid
//  in_ready    out  1      unit can accept input this cycle
//  in_op       in   3      operation code (see BEHAVIOUR)
//  in_a        in   WIDTH  operand A
//  in_b        in   WIDTH  operand B
//  out_valid   out  1      result valid
//  out_ready   in   1      downstream accepts result
//  out_y       out  WIDTH  result
//  out_zero    out  1      1 when out_y == 0
//  out_parity  out  1      XOR-reduction of out_y
//  acc_q       out  WIDTH  current accumulator value
// BEHAVIOUR
//  Reset: async on rst_n low. s1_valid=0, out_valid=0, out_y=0, out_zero=0, out_parity=0, acc_q=0.
//  Reset: stage registers cleared. in_ready=1 from the first edge after release.
//  Ops: 000 AND, 001 OR, 010 XOR, 011 XNOR, 100 NAND, 101 NOR.
//  Ops: 110 ACC_XOR: y = acc^a^b and acc <= y.
//  Ops: 111 ACC_LOAD: y = a^b and acc <= y.
//  Ops: ops 000-101 never modify acc.
//  Pipeline stage 1: register {op,a,b} on in_valid && in_ready.
//  Pipeline stage 2: compute, register out_y and flags, update acc when stage 1 advances.
//  Latency: exactly 2 cycles from accepted input to out_valid, with no stall.
//  Throughput: 1 transaction/cycle.
//  Handshake: adv2 = !out_valid || out_ready; adv1 = s1_valid && adv2.
//  Handshake: in_ready = !s1_valid || adv2 (combinational from out_ready; max 2 in flight).
//  Handshake: out_valid rises on adv1. It falls on out_ready && !adv1.
//  Stall: while out_valid && !out_ready, out_y/out_zero/out_parity are held stable.
//  Stall: acc is not updated; a queued ACC op waits in stage 1.
//  Ordering: results leave strictly in acceptance order; no drop, no duplicate.
//  Chained ACC ops back-to-back: each sees acc as updated by the previous op (acc update and stage-2 capture share the edge).
//  in_valid low: bubble propagates. Held data never changes while out_valid && !out_ready.
//  Reset mid-operation: in-flight transactions discarded, acc cleared, outputs return to reset values immediately.
//  Width: all ops bitwise on WIDTH bits; no carries; out_parity = ^out_y.
// STRUCTURE
//  logic_unit_pkg: localparams/enum for the 8 op codes.
//  logic_unit_pkg: op-code width constant (3).
//  logic_unit_core: combinational sub-module, (op, a, b, acc) -> (y, acc_next, acc_we).
//  logic_unit_core: instantiated once in stage 2.
//  Top level holds: stage-1 register, stage-2 output register, acc register, handshake logic.
// TESTING (WIDTH=32)
//  Reset: hold rst_n=0 for 3 clocks, release -> out_valid=0, acc_q=0, in_ready=1.
//  XOR: a=FFFF0000, b=0F0F0F0F -> after 2 clks out_y=F0F00F0F, zero=0, parity=0.
//  AND: a=0000FFFF, b=FFFF0000 -> out_y=00000000, zero=1, parity=0.
//  NOR: a=0, b=0 -> out_y=FFFFFFFF, parity=0.
//  Accumulate, op 1: back-to-back ACC_LOAD a=12345678 b=0 -> y=12345678.
//  Accumulate, op 2: then ACC_XOR a=12345678 b=00000001 -> y=00000001, parity=1, acc_q=00000001.
//  Backpressure, stall: out_ready=0, stream ops 1..3 -> in_ready drops after 2 accepted; out_y of op1 stable.
//  Backpressure, release: out_ready=1 -> op1..op3 delivered in order; acc unchanged by non-ACC ops.
//  Reset mid-flight: both stages full, pulse rst_n low between clock edges -> out_valid=0 and acc_q=0 at once; no stale result after release.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared op-code definitions for the pipelined bitwise logic unit.
package logic_unit_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND      = 3'b000,
        OP_OR       = 3'b001,
        OP_XOR      = 3'b010,
        OP_XNOR     = 3'b011,
        OP_NAND     = 3'b100,
        OP_NOR      = 3'b101,
        OP_ACC_XOR  = 3'b110,
        OP_ACC_LOAD = 3'b111
    } op_e;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational datapath: selects the bitwise result and decides whether the
// accumulator takes it.
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  op_e              i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_acc,
    output logic [WIDTH-1:0] o_y,
    output logic [WIDTH-1:0] o_acc_next,
    output logic             o_acc_we
);

    always_comb begin
        o_y      = '0;
        o_acc_we = 1'b0;
        case (i_op)
            OP_AND:      o_y = i_a & i_b;
            OP_OR:       o_y = i_a | i_b;
            OP_XOR:      o_y = i_a ^ i_b;
            OP_XNOR:     o_y = ~(i_a ^ i_b);
            OP_NAND:     o_y = ~(i_a & i_b);
            OP_NOR:      o_y = ~(i_a | i_b);
            OP_ACC_XOR: begin
                o_y      = i_acc ^ i_a ^ i_b;
                o_acc_we = 1'b1;
            end
            OP_ACC_LOAD: begin
                o_y      = i_a ^ i_b;
                o_acc_we = 1'b1;
            end
            default: begin
                o_y      = '0;
                o_acc_we = 1'b0;
            end
        endcase
    end

    // Accumulator always takes the result itself; o_acc_we gates it.
    assign o_acc_next = o_y;

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit with an XOR accumulator and
// zero/parity flags on the registered result.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_parity,
    output logic [WIDTH-1:0] acc_q
);

    logic             r_s1_valid;
    op_e              r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_y;
    logic             r_out_zero;
    logic             r_out_parity;
    logic [WIDTH-1:0] r_acc;

    logic             w_adv1;
    logic             w_adv2;
    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_acc_we;

    // Stage 2 frees up whenever it is empty or its result is being taken.
    assign w_adv2   = !r_out_valid || out_ready;
    assign w_adv1   = r_s1_valid && w_adv2;
    assign in_ready = !r_s1_valid || w_adv2;

    logic_unit_core #(.WIDTH(WIDTH)) u_core (
        .i_op       (r_s1_op),
        .i_a        (r_s1_a),
        .i_b        (r_s1_b),
        .i_acc      (r_acc),
        .o_y        (w_y),
        .o_acc_next (w_acc_next),
        .o_acc_we   (w_acc_we)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= OP_AND;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_op <= op_e'(in_op);
                r_s1_a  <= in_a;
                r_s1_b  <= in_b;
            end
        end
    end

    // The accumulator moves on the same edge as the stage-2 capture, so a
    // following ACC op in stage 1 already sees the updated value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_y      <= '0;
            r_out_zero   <= 1'b0;
            r_out_parity <= 1'b0;
            r_acc        <= '0;
        end else begin
            if (w_adv2) begin
                r_out_valid <= r_s1_valid;
            end
            if (w_adv1) begin
                r_out_y      <= w_y;
                r_out_zero   <= (w_y == '0);
                r_out_parity <= ^w_y;
                if (w_acc_we) begin
                    r_acc <= w_acc_next;
                end
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_y      = r_out_y;
    assign out_zero   = r_out_zero;
    assign out_parity = r_out_parity;
    assign acc_q      = r_acc;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed-vector bench for logic_unit_pipe (WIDTH=32).
module tb_logic_unit_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;
    logic        out_zero;
    logic        out_parity;
    logic [31:0] acc_q;

    int n_cmp = 0;
    int n_bad = 0;

    logic_unit_pipe #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_zero   (out_zero),
        .out_parity (out_parity),
        .acc_q      (acc_q)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        in_op    = op;
        in_a     = a;
        in_b     = b;
    endtask

    // Single transaction with out_ready high; result is sampled 2 edges later.
    task automatic single_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp_y,
                             input logic exp_zero, input logic exp_par);
        @(negedge clk);
        drive(1'b1, op, a, b);
        @(posedge clk);
        #1 drive(1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        check_eq({tag, "_early_valid"}, {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        check_eq({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check_eq({tag, "_y"}, out_y, exp_y);
        check_eq({tag, "_zero"}, {31'b0, out_zero}, {31'b0, exp_zero});
        check_eq({tag, "_parity"}, {31'b0, out_parity}, {31'b0, exp_par});
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst_acc", acc_q, 32'h0);
        check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check_eq("rst_out_y", out_y, 32'h0);

        single_op("xor", 3'b010, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0, 1'b0);
        single_op("and", 3'b000, 32'h0000FFFF, 32'hFFFF0000, 32'h00000000, 1'b1, 1'b0);
        single_op("nor", 3'b101, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        check_eq("acc_after_plain_ops", acc_q, 32'h0);

        // Back-to-back ACC_LOAD then ACC_XOR.
        @(negedge clk);
        drive(1'b1, 3'b111, 32'h12345678, 32'h0);
        @(negedge clk);
        check_eq("acc_in_ready", {31'b0, in_ready}, 32'd1);
        drive(1'b1, 3'b110, 32'h12345678, 32'h00000001);
        @(negedge clk);
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        check_eq("acc_load_valid", {31'b0, out_valid}, 32'd1);
        check_eq("acc_load_y", out_y, 32'h12345678);
        check_eq("acc_load_acc", acc_q, 32'h12345678);
        @(negedge clk);
        check_eq("acc_xor_valid", {31'b0, out_valid}, 32'd1);
        check_eq("acc_xor_y", out_y, 32'h00000001);
        check_eq("acc_xor_parity", {31'b0, out_parity}, 32'd1);
        check_eq("acc_xor_acc", acc_q, 32'h00000001);
        @(negedge clk);
        check_eq("acc_drain_valid", {31'b0, out_valid}, 32'd0);

        // Backpressure: op1 OR, op2 XNOR, op3 NAND with out_ready low.
        out_ready = 1'b0;
        drive(1'b1, 3'b001, 32'h000000F0, 32'h0000000F);
        check_eq("bp_ready0", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        check_eq("bp_ready1", {31'b0, in_ready}, 32'd1);
        drive(1'b1, 3'b011, 32'h00000000, 32'h00000000);
        @(negedge clk);
        check_eq("bp_op1_valid", {31'b0, out_valid}, 32'd1);
        check_eq("bp_op1_y", out_y, 32'h000000FF);
        check_eq("bp_ready_drop", {31'b0, in_ready}, 32'd0);
        drive(1'b1, 3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (2) begin
            @(negedge clk);
            check_eq("bp_stall_ready", {31'b0, in_ready}, 32'd0);
            check_eq("bp_stall_y", out_y, 32'h000000FF);
            check_eq("bp_stall_valid", {31'b0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        #1 check_eq("bp_release_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        check_eq("bp_op2_y", out_y, 32'hFFFFFFFF);
        check_eq("bp_op2_valid", {31'b0, out_valid}, 32'd1);
        @(negedge clk);
        check_eq("bp_op3_y", out_y, 32'h00000000);
        check_eq("bp_op3_zero", {31'b0, out_zero}, 32'd1);
        check_eq("bp_op3_valid", {31'b0, out_valid}, 32'd1);
        @(negedge clk);
        check_eq("bp_drain_valid", {31'b0, out_valid}, 32'd0);
        check_eq("bp_acc_kept", acc_q, 32'h00000001);

        // Reset mid-flight with both stages full.
        out_ready = 1'b0;
        drive(1'b1, 3'b111, 32'hAAAA5555, 32'h0);
        @(negedge clk);
        drive(1'b1, 3'b010, 32'h1, 32'h2);
        @(negedge clk);
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        check_eq("mid_acc_loaded", acc_q, 32'hAAAA5555);
        check_eq("mid_full_valid", {31'b0, out_valid}, 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check_eq("mid_rst_acc", acc_q, 32'h0);
        check_eq("mid_rst_y", out_y, 32'h0);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("mid_no_stale", {31'b0, out_valid}, 32'd0);
        end
        check_eq("mid_acc_after", acc_q, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
